uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester UART transmit scheduler: arbitrates byte requests from two on-chip sources (port A: inference result stream, port B: debug/status stream), sequences a baud-tick generator, and serialises each granted byte as an 8N1 frame on the board TX line. It sits between the classifier/debug logic and the UART pin. Only one frame is on the line at any time.

## Interface
- SYS_RATE, 100000000, system clock frequency in Hz
- BAND_RATE, 921600, line baud rate in bits/s
- CNT_BAND, SYS_RATE / BAND_RATE (=108), clock cycles per bit (derived; legal range 2..16383)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- a_valid  input  1  port A holds a byte to send
- a_data  input  8  port A byte, stable while a_valid && !a_ready
- a_ready  output  1  port A byte accepted this cycle
- b_valid  input  1  port B holds a byte to send
- b_data  input  8  port B byte, stable while b_valid && !b_ready
- b_ready  output  1  port B byte accepted this cycle
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state != IDLE)
- gnt_b  output  1  source of current/last frame: 0 = A, 1 = B
- frame_done  output  1  one-cycle pulse on last cycle of stop bit

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. Selection: only one valid -> that port; both valid -> port not granted last (last_grant register). a_ready = IDLE && sel==A && a_valid; b_ready likewise. At most one ready high per cycle. Handshake (valid && ready) latches data into shift register, sets gnt_b and last_grant, goes to START.
- START: tx=0 for CNT_BAND cycles, then DATA with bit index 0.
- DATA: tx = shift[0], LSB first; each bit held CNT_BAND cycles; on tick shift right, index+1; after index 7 completes, go to STOP.
- STOP: tx=1 for CNT_BAND cycles; frame_done pulses on the final cycle; next state IDLE.
- Baud timing: 14-bit counter, cleared on handshake, counts 0..CNT_BAND-1 while busy, tick when count==CNT_BAND-1, then wraps to 0. Counter held at 0 in IDLE.
- Valid deasserted while not ready: no effect, no frame. Valids ignored outside IDLE.
- Reset (rst=0 at an edge), including mid-frame: next cycle tx=1, busy=0, a_ready=b_ready=0, frame_done=0, gnt_b=0, last_grant=B (so A wins first tie), counter=0, state IDLE; in-flight byte dropped, no partial stop bit.

## Timing
- Reset values: tx=1, busy=0, gnt_b=0, frame_done=0; a_ready/b_ready are combinational and low during reset.
- Handshake at cycle T -> tx falls at T+1; start bit cycles T+1..T+CNT_BAND; data bit k at T+1+(k+1)*CNT_BAND; stop bit ends at T+10*CNT_BAND with frame_done high in that cycle.
- Frame occupies exactly 10*CNT_BAND cycles; earliest next handshake T+10*CNT_BAND+1 (one idle cycle, tx=1), giving period 10*CNT_BAND+1.
- ready is combinational from state, valids and last_grant; no registered latency on accept.

## Structure
- Shared package uart_pkg: state enum (IDLE/START/DATA/STOP), default SYS_RATE/BAND_RATE constants, CNT_BAND derivation function.
- One sub-module: uart_bps_tick (enable, clear, tick out; 14-bit counter, same clk/rst convention). Arbiter, FSM and shift register stay in the top.

## Test plan
- Sim params SYS_RATE=1000, BAND_RATE=100 (CNT_BAND=10). Reset, idle -> tx=1, busy=0, both ready low for 20 cycles.
- A sends 0x55 -> tx low cycles 1-10 after handshake, then 1,0,1,0,1,0,1,0 per 10 cycles, high 10 cycles; frame_done at +100; gnt_b=0.
- A=0xA3, B=0x3C both valid same cycle after reset -> A framed first, b_ready at A-handshake+101, B frame on line; gnt_b toggles 0->1.
- Both held valid continuously for 4 frames -> grant order A,B,A,B; inter-frame gap exactly 1 cycle.
- Reset asserted at cycle 35 of a 0xFF frame -> tx=1, busy=0 next cycle; pending B valid accepted first cycle after reset release only if A not valid.
- b_valid pulsed 1 cycle while busy -> no b_ready, no extra frame; line count stays 1 frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default rates and bit-period derivation for the UART TX scheduler.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int SYS_RATE_DEF  = 100000000;
    localparam int BAND_RATE_DEF = 921600;

    function automatic int cnt_band(input int sys_rate, input int band_rate);
        return sys_rate / band_rate;
    endfunction

endpackage

// File: rtl/uart_bps_tick.sv
// uart_bps_tick: bit-period counter, pulses tick on the last cycle of every bit while enabled.
module uart_bps_tick #(
    parameter int CNT_BAND = 108
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    logic [13:0] cnt;

    assign tick = enable && cnt == 14'(CNT_BAND - 1);

    always_ff @(posedge clk) begin
        if (!rst || clear || !enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 14'd1;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-port round-robin byte arbiter feeding a single 8N1 UART transmitter.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int SYS_RATE  = SYS_RATE_DEF,
    parameter int BAND_RATE = BAND_RATE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       tx,
    output logic       busy,
    output logic       gnt_b,
    output logic       frame_done
);

    localparam int CNT_BAND = cnt_band(SYS_RATE, BAND_RATE);

    state_t     state, state_d;
    logic [7:0] shift, shift_d;
    logic [2:0] idx, idx_d;
    logic       gnt_d, last_grant, last_d;
    logic       idle, sel_b, hs, tick;

    assign idle       = state == IDLE;
    // On a tie the port that did not win last time gets the line.
    assign sel_b      = b_valid && (!a_valid || !last_grant);
    assign a_ready    = rst && idle && a_valid && !sel_b;
    assign b_ready    = rst && idle && sel_b;
    assign hs         = a_ready || b_ready;
    assign busy       = !idle;
    assign frame_done = state == STOP && tick;
    assign tx         = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;

    uart_bps_tick #(.CNT_BAND(CNT_BAND)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (busy),
        .clear  (hs),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            gnt_b      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            idx        <= idx_d;
            gnt_b      <= gnt_d;
            last_grant <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        shift_d = shift;
        idx_d   = idx;
        gnt_d   = gnt_b;
        last_d  = last_grant;
        case (state)
            IDLE: if (hs) begin
                state_d = START;
                shift_d = sel_b ? b_data : a_data;
                gnt_d   = sel_b;
                last_d  = sel_b;
            end
            START: if (tick) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (tick) begin
                shift_d = shift >> 1;
                idx_d   = idx + 3'd1;
                state_d = idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of arbitration, 8N1 framing, reset abort and busy-time valid pulses.
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, tx, busy, gnt_b, frame_done;
    int         checks = 0;
    int         errs = 0;

    uart_tx_sched #(.SYS_RATE(1000), .BAND_RATE(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .tx         (tx),
        .busy       (busy),
        .gnt_b      (gnt_b),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // n counts cycles after the handshake edge: start 1..10, bit k 11+10k..20+10k, stop 91..100.
    function automatic logic exp_tx(input logic [7:0] d, input int n);
        if (n <= 10) return 1'b0;
        if (n <= 90) return d[(n - 11) / 10];
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic g, input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            chk($sformatf("tx d=%h n=%0d", d, n), tx, exp_tx(d, n));
            chk($sformatf("busy d=%h n=%0d", d, n), busy, 1'b1);
            chk($sformatf("frame_done d=%h n=%0d", d, n), frame_done, n == 100);
            chk($sformatf("gnt_b d=%h n=%0d", d, n), gnt_b, g);
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " tx"}, tx, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    task automatic send_a(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        #1;
        chk("send_a a_ready", a_ready, 1'b1);
        chk("send_a b_ready", b_ready, 1'b0);
        step();
        a_valid = 1'b0;
    endtask

    initial begin
        // reset: outputs idle, readies held low even with valids present
        a_valid = 1'b1;
        b_valid = 1'b1;
        step();
        step();
        #1;
        check_idle("reset");
        chk("reset gnt_b", gnt_b, 1'b0);
        chk("reset a_ready", a_ready, 1'b0);
        chk("reset b_ready", b_ready, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle($sformatf("idle%0d", i));
            chk($sformatf("idle%0d a_ready", i), a_ready, 1'b0);
            chk($sformatf("idle%0d b_ready", i), b_ready, 1'b0);
        end

        // single A frame 0x55
        send_a(8'h55);
        run_frame(8'h55, 1'b0, 1, 100);
        check_idle("after55");

        // simultaneous A/B after reset: A first, B at +101
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        a_valid = 1'b1;
        a_data  = 8'hA3;
        b_valid = 1'b1;
        b_data  = 8'h3C;
        #1;
        chk("tie a_ready", a_ready, 1'b1);
        chk("tie b_ready", b_ready, 1'b0);
        step();
        a_valid = 1'b0;
        run_frame(8'hA3, 1'b0, 1, 100);
        check_idle("tie gap");
        chk("tie gap b_ready", b_ready, 1'b1);
        chk("tie gap a_ready", a_ready, 1'b0);
        step();
        b_valid = 1'b0;
        run_frame(8'h3C, 1'b1, 1, 100);
        check_idle("afterB");

        // both held valid: alternate A,B,A,B with one idle cycle between frames
        a_valid = 1'b1;
        a_data  = 8'hC6;
        b_valid = 1'b1;
        b_data  = 8'h39;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d a_ready", i), a_ready, (i % 2) == 0);
            chk($sformatf("rr%0d b_ready", i), b_ready, (i % 2) == 1);
            step();
            run_frame((i % 2) ? 8'h39 : 8'hC6, (i % 2) == 1, 1, 100);
            check_idle($sformatf("rr%0d gap", i));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();

        // reset in the middle of a 0xFF frame
        send_a(8'hFF);
        run_frame(8'hFF, 1'b0, 1, 34);
        rst     = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'h5A;
        #1;
        chk("abort b_ready in reset", b_ready, 1'b0);
        step();
        check_idle("abort");
        chk("abort gnt_b", gnt_b, 1'b0);
        chk("abort b_ready", b_ready, 1'b0);
        rst     = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'h81;
        #1;
        chk("release a_ready", a_ready, 1'b1);
        chk("release b_ready", b_ready, 1'b0);
        a_valid = 1'b0;
        #1;
        chk("release only B b_ready", b_ready, 1'b1);
        step();
        b_valid = 1'b0;
        run_frame(8'h5A, 1'b1, 1, 100);
        check_idle("after5A");

        // b_valid pulse while busy is ignored
        send_a(8'h0F);
        run_frame(8'h0F, 1'b0, 1, 49);
        b_valid = 1'b1;
        b_data  = 8'hE7;
        #1;
        chk("pulse b_ready", b_ready, 1'b0);
        run_frame(8'h0F, 1'b0, 50, 50);
        b_valid = 1'b0;
        run_frame(8'h0F, 1'b0, 51, 100);
        for (int i = 0; i < 15; i++) begin
            check_idle($sformatf("post pulse%0d", i));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
